// File: rtl/hit_count_memory.sv
// Per-address hit counter RAM with a 2-stage read-modify-write pipeline,
// bulk clear sweep, registered readout and saturating hit total.
module hit_count_memory #(
  parameter int ADDRESSBITS = 8,
  parameter int NROWS       = 256,
  parameter int COUNTBITS   = 8,
  parameter int TOTALBITS   = 16
) (
  input  logic                   clock,
  input  logic                   nReset,
  input  logic [ADDRESSBITS-1:0] address,
  input  logic                   newAddress,
  output logic                   storageReady,
  input  logic                   clearRequest,
  input  logic                   readRequest,
  input  logic [ADDRESSBITS-1:0] readAddress,
  output logic [COUNTBITS-1:0]   readData,
  output logic                   readValid,
  output logic                   saturated,
  output logic                   droppedHit,
  output logic [TOTALBITS-1:0]   hitTotal
);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_READY,
    S_DRAIN
  } state_e;

  localparam logic [ADDRESSBITS-1:0] LAST_ROW =
    ADDRESSBITS'(NROWS - 1);

  state_e state_q, state_d;
  logic [ADDRESSBITS-1:0] row_q, row_d;

  logic                   valid_a_q;
  logic [ADDRESSBITS-1:0] addr_a_q;
  logic                   valid_b_q;
  logic [ADDRESSBITS-1:0] addr_b_q;
  logic [COUNTBITS-1:0]   val_b_q;

  logic [COUNTBITS-1:0] mem_q [NROWS];

  logic                 accept;
  logic                 pipe_busy;
  logic                 enter_clear;
  logic                 rd_en;
  logic [COUNTBITS-1:0] old_cnt;
  logic [COUNTBITS-1:0] next_cnt;
  logic                 old_full;

  assign storageReady = (state_q == S_READY);
  assign accept       = newAddress && storageReady;
  assign pipe_busy    = valid_a_q || valid_b_q;
  assign rd_en        = readRequest && storageReady;
  assign enter_clear  = (state_d == S_CLEAR) && (state_q != S_CLEAR);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    unique case (state_q)
      S_CLEAR: begin
        row_d = row_q + 1'b1;
        if (row_q == LAST_ROW) state_d = S_READY;
      end
      S_READY: begin
        if (clearRequest) begin
          if (pipe_busy) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_CLEAR;
            row_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        if (!pipe_busy) begin
          state_d = S_CLEAR;
          row_d   = '0;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Forward the stage-B value when it targets the row being read.
  always_comb begin
    old_cnt = mem_q[addr_a_q];
    if (valid_b_q && (addr_b_q == addr_a_q)) old_cnt = val_b_q;
    old_full = &old_cnt;
    next_cnt = old_full ? old_cnt : old_cnt + 1'b1;
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= S_CLEAR;
      row_q      <= '0;
      valid_a_q  <= 1'b0;
      addr_a_q   <= '0;
      valid_b_q  <= 1'b0;
      addr_b_q   <= '0;
      val_b_q    <= '0;
      readData   <= '0;
      readValid  <= 1'b0;
      saturated  <= 1'b0;
      droppedHit <= 1'b0;
      hitTotal   <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      valid_a_q <= accept;
      if (accept) addr_a_q <= address;
      valid_b_q <= valid_a_q;
      if (valid_a_q) begin
        addr_b_q <= addr_a_q;
        val_b_q  <= next_cnt;
      end
      readValid <= rd_en;
      if (rd_en) readData <= mem_q[readAddress];
      if (enter_clear) begin
        hitTotal   <= '0;
        saturated  <= 1'b0;
        droppedHit <= 1'b0;
      end else begin
        if (accept && !(&hitTotal)) hitTotal <= hitTotal + 1'b1;
        if (valid_a_q && old_full) saturated <= 1'b1;
        if (newAddress && !storageReady) droppedHit <= 1'b1;
      end
    end
  end

  // Sweep and pipeline writes never overlap: CLEAR is only entered empty.
  always_ff @(posedge clock) begin
    if (state_q == S_CLEAR) begin
      mem_q[row_q] <= '0;
    end else if (valid_b_q) begin
      mem_q[addr_b_q] <= val_b_q;
    end
  end

endmodule

// File: tb/tb_hit_count_memory.sv
// Bench for hit_count_memory: directed steps plus random hits,
// checked against an array-based count model.
module tb_hit_count_memory;

  logic       clock = 1'b0;
  logic       nReset = 1'b1;
  logic [7:0] address = '0;
  logic       newAddress = 1'b0;
  logic       storageReady;
  logic       clearRequest = 1'b0;
  logic       readRequest = 1'b0;
  logic [7:0] readAddress = '0;
  logic [7:0] readData;
  logic       readValid;
  logic       saturated;
  logic       droppedHit;
  logic [15:0] hitTotal;

  int checks = 0;
  int errors = 0;

  int unsigned m_cnt [256];
  int unsigned m_total;
  logic        m_sat;
  logic        m_drop;

  always #5 clock = ~clock;

  hit_count_memory dut (
    .clock       (clock),
    .nReset      (nReset),
    .address     (address),
    .newAddress  (newAddress),
    .storageReady(storageReady),
    .clearRequest(clearRequest),
    .readRequest (readRequest),
    .readAddress (readAddress),
    .readData    (readData),
    .readValid   (readValid),
    .saturated   (saturated),
    .droppedHit  (droppedHit),
    .hitTotal    (hitTotal)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic model_hit(input logic [7:0] a);
    if (m_cnt[a] == 255) m_sat = 1'b1;
    else m_cnt[a] = m_cnt[a] + 1;
    if (m_total != 65535) m_total = m_total + 1;
  endtask

  task automatic model_clear();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_total = 0;
    m_sat   = 1'b0;
    m_drop  = 1'b0;
  endtask

  task automatic hits(input logic [7:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      address    = a;
      newAddress = 1'b1;
      tick();
      model_hit(a);
    end
    newAddress = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input string tag);
    readAddress = a;
    readRequest = 1'b1;
    tick();
    readRequest = 1'b0;
    chk({tag, "_valid"}, 32'(readValid), 32'd1);
    chk(tag, 32'(readData), m_cnt[a]);
  endtask

  task automatic status(input string tag, input logic rdy);
    chk({tag, "_total"}, 32'(hitTotal), m_total);
    chk({tag, "_sat"}, 32'(saturated), 32'(m_sat));
    chk({tag, "_drop"}, 32'(droppedHit), 32'(m_drop));
    chk({tag, "_ready"}, 32'(storageReady), 32'(rdy));
  endtask

  task automatic wait_ready(input int start, input string tag);
    int n;
    n = start;
    while (!storageReady && n < 1000) begin
      tick();
      n++;
    end
    chk(tag, n, 32'd256);
  endtask

  initial begin
    int unsigned r;
    logic [7:0] seq [3];
    seq[0] = 8'h04;
    seq[1] = 8'hD0;
    seq[2] = 8'h54;
    model_clear();

    #1 nReset = 1'b0;
    repeat (10) tick();
    chk("rst_readData", 32'(readData), 32'd0);
    chk("rst_readValid", 32'(readValid), 32'd0);
    status("rst", 1'b0);
    nReset = 1'b1;
    wait_ready(0, "sweep_after_reset");
    status("ready", 1'b1);
    rd(8'h00, "init_00");
    rd(8'h54, "init_54");
    rd(8'hFF, "init_FF");
    tick();
    chk("readValid_fall", 32'(readValid), 32'd0);

    foreach (seq[i]) hits(seq[i], 1);
    repeat (2) tick();
    foreach (seq[i]) rd(seq[i], "three_hits");
    status("three_hits", 1'b1);

    hits(8'h87, 5);
    repeat (2) tick();
    rd(8'h87, "fwd_87");
    status("fwd", 1'b1);

    hits(8'h33, 300);
    repeat (2) tick();
    rd(8'h33, "sat_33");
    status("sat", 1'b1);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 7);
      address = 8'(8'h60 + r);
      newAddress = 1'($urandom_range(0, 1));
      tick();
      if (newAddress) model_hit(address);
    end
    newAddress = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 8; i++) rd(8'(8'h60 + i), "rand");
    status("rand", 1'b1);

    hits(8'h10, 1);
    hits(8'h11, 1);
    clearRequest = 1'b1;
    tick();
    clearRequest = 1'b0;
    chk("drain_ready", 32'(storageReady), 32'd0);
    address = 8'h22;
    newAddress = 1'b1;
    tick();
    newAddress = 1'b0;
    m_drop = 1'b1;
    status("drain", 1'b0);
    tick();
    model_clear();
    status("clear_entry", 1'b0);
    readAddress = 8'h10;
    readRequest = 1'b1;
    tick();
    readRequest = 1'b0;
    chk("clear_read_ignored", 32'(readValid), 32'd0);
    wait_ready(1, "sweep_after_clear");
    rd(8'h10, "cleared_10");
    rd(8'h11, "cleared_11");
    rd(8'h33, "cleared_33");
    rd(8'h87, "cleared_87");
    status("cleared", 1'b1);

    hits(8'h42, 3);
    repeat (2) tick();
    rd(8'h42, "pre_reset_42");
    clearRequest = 1'b1;
    tick();
    clearRequest = 1'b0;
    model_clear();
    repeat (100) tick();
    chk("hold_readData", 32'(readData), 32'd3);
    nReset = 1'b0;
    #1;
    chk("async_readData", 32'(readData), 32'd0);
    status("async_rst", 1'b0);
    repeat (3) tick();
    nReset = 1'b1;
    wait_ready(0, "sweep_restart");
    rd(8'h42, "restart_42");
    status("end", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
